data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface: services the word address, write data and write enable issued by the pipeline's MEM stage, and returns read data in the same cycle.
- Contains a word-addressed data RAM plus a memory-mapped I/O (MMIO) page:
  - free-running cycle counter
  - general-purpose output register
  - byte transmit FIFO drained by an external ready/valid consumer
- Sits beside the CPU at top level, replacing a bare RAM.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus plus the transmit-byte stream and GPIO outputs of the responder.
// master = CPU / consumer side, slave = responder side.
interface data_mem_responder_if #(
    parameter int N = 32
);
    logic [N-1:0] data_mem_address_i;
    logic [N-1:0] data_mem_in_data_i;
    logic         data_mem_WE_i;
    logic [N-1:0] data_mem_out_data_o;
    logic [N-1:0] gpio_o;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;

    modport master (
        output data_mem_address_i, data_mem_in_data_i, data_mem_WE_i, tx_ready_i,
        input  data_mem_out_data_o, gpio_o, tx_data_o, tx_valid_o
    );

    modport slave (
        input  data_mem_address_i, data_mem_in_data_i, data_mem_WE_i, tx_ready_i,
        output data_mem_out_data_o, gpio_o, tx_data_o, tx_valid_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus an MMIO page holding a cycle counter,
// a GPIO output register and a byte transmit FIFO with a sticky status word.
module data_mem_responder #(
    parameter int           N          = 32,
    parameter int           RAM_DEPTH  = 1024,
    parameter int           FIFO_DEPTH = 8,
    parameter logic [N-1:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input logic                CLK,
    input logic                RST,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         we;
    logic [1:0]   off;
    logic         is_ram;
    logic         is_mmio;

    assign addr    = bus.data_mem_address_i;
    assign wdata   = bus.data_mem_in_data_i;
    assign we      = bus.data_mem_WE_i;
    assign off     = addr[1:0];
    assign is_ram  = addr < N'(RAM_DEPTH);
    assign is_mmio = addr[N-1:2] == MMIO_BASE[N-1:2];

    logic [N-1:0] ram [RAM_DEPTH];
    logic [7:0]   fifo_mem [FIFO_DEPTH];

    logic [N-1:0] cycle_cnt;
    logic [N-1:0] gpio;
    logic [7:0]   tx_data;
    logic [PW:0]  count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic         overflow;
    logic         bad_addr;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic push_ok;
    logic ovf_set;
    logic bad_set;
    logic ovf_clr;
    logic bad_clr;
    logic [N-1:0] status;

    assign empty   = count == '0;
    assign full    = count == (PW+1)'(FIFO_DEPTH);
    assign rd_next = rd_ptr + 1'b1;
    assign pop     = !empty && bus.tx_ready_i;
    assign push    = we && is_mmio && off == 2'd2;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && !push_ok;
    assign bad_set = we && !is_ram && !is_mmio;
    assign ovf_clr = we && is_mmio && off == 2'd3 && wdata[2];
    assign bad_clr = we && is_mmio && off == 2'd3 && wdata[3];

    always_comb begin
        status          = '0;
        status[0]       = empty;
        status[1]       = full;
        status[2]       = overflow;
        status[3]       = bad_addr;
        status[8+PW:8]  = count;
    end

    always_comb begin
        bus.data_mem_out_data_o = '0;
        if (is_ram) begin
            bus.data_mem_out_data_o = ram[addr[AW-1:0]];
        end else if (is_mmio) begin
            case (off)
                2'd0:    bus.data_mem_out_data_o = cycle_cnt;
                2'd1:    bus.data_mem_out_data_o = gpio;
                2'd2:    bus.data_mem_out_data_o = '0;
                default: bus.data_mem_out_data_o = status;
            endcase
        end
    end

    // Storage arrays are not reset; writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (!RST && we && is_ram) begin
            ram[addr[AW-1:0]] <= wdata;
        end
        if (!RST && push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_cnt <= '0;
            gpio      <= '0;
            tx_data   <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            bad_addr  <= 1'b0;
        end else begin
            if (we && is_mmio && off == 2'd0) begin
                cycle_cnt <= wdata;
            end else begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end

            if (we && is_mmio && off == 2'd1) begin
                gpio <= wdata;
            end

            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Registered head byte; it keeps its last value once the FIFO drains.
            case ({push_ok, pop})
                2'b11:   tx_data <= (count == 1) ? wdata[7:0] : fifo_mem[rd_next];
                2'b01:   if (count > 1) tx_data <= fifo_mem[rd_next];
                2'b10:   if (empty) tx_data <= wdata[7:0];
                default: tx_data <= tx_data;
            endcase

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (bad_set) begin
                bad_addr <= 1'b1;
            end else if (bad_clr) begin
                bad_addr <= 1'b0;
            end
        end
    end

    assign bus.gpio_o     = gpio;
    assign bus.tx_data_o  = tx_data;
    assign bus.tx_valid_o = !empty;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios then random traffic,
// all checked against a queue-based behavioural model.
module tb_data_mem_responder;
    localparam logic [31:0] MM = 32'hFFFF_FF00;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    data_mem_responder_if #(.N(32)) bus ();

    data_mem_responder #(
        .N(32), .RAM_DEPTH(1024), .FIFO_DEPTH(8), .MMIO_BASE(MM)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram_m [int];
    logic [31:0] cnt_m;
    logic [31:0] gpio_m;
    logic [7:0]  txd_m;
    logic        ovf_m;
    logic        bad_m;
    logic [7:0]  q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cnt_m  = '0;
        gpio_m = '0;
        txd_m  = '0;
        ovf_m  = 1'b0;
        bad_m  = 1'b0;
        q.delete();
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(q.size()) << 8;
        s[0] = (q.size() == 0);
        s[1] = (q.size() == 8);
        s[2] = ovf_m;
        s[3] = bad_m;
        return s;
    endfunction

    // One bus cycle: drive, check the combinational view mid-cycle, then advance the model at the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        logic        known;
        logic [31:0] exp_rd;
        logic        do_pop;
        logic        do_push;
        logic        acc;
        bus.data_mem_address_i = a;
        bus.data_mem_in_data_i = d;
        bus.data_mem_WE_i      = w;
        bus.tx_ready_i         = r;
        @(negedge CLK);
        known  = 1'b1;
        exp_rd = '0;
        if (a < 1024) begin
            if (ram_m.exists(int'(a))) exp_rd = ram_m[int'(a)];
            else known = 1'b0;
        end else if (a[31:2] == MM[31:2]) begin
            case (a[1:0])
                2'd0: exp_rd = cnt_m;
                2'd1: exp_rd = gpio_m;
                2'd2: exp_rd = '0;
                default: exp_rd = model_status();
            endcase
        end
        if (known) chk("read_data", bus.data_mem_out_data_o, exp_rd);
        chk("gpio", bus.gpio_o, gpio_m);
        chk("tx_valid", 32'(bus.tx_valid_o), 32'(q.size() != 0));
        chk("tx_data", 32'(bus.tx_data_o), 32'(txd_m));

        do_pop  = (q.size() != 0) && r;
        do_push = w && a[31:2] == MM[31:2] && a[1:0] == 2'd2;
        acc     = do_push && (q.size() < 8 || do_pop);
        if (do_pop) void'(q.pop_front());
        if (acc) q.push_back(d[7:0]);
        if (q.size() != 0) txd_m = q[0];
        if (w && a[31:2] == MM[31:2] && a[1:0] == 2'd3) begin
            if (d[2]) ovf_m = 1'b0;
            if (d[3]) bad_m = 1'b0;
        end
        if (do_push && !acc) ovf_m = 1'b1;
        if (w && a >= 1024 && a[31:2] != MM[31:2]) bad_m = 1'b1;
        if (w && a[31:2] == MM[31:2] && a[1:0] == 2'd0) cnt_m = d;
        else cnt_m = cnt_m + 1;
        if (w && a[31:2] == MM[31:2] && a[1:0] == 2'd1) gpio_m = d;
        if (w && a < 1024) ram_m[int'(a)] = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bus.data_mem_address_i = MM + 3;
        bus.data_mem_in_data_i = '0;
        bus.data_mem_WE_i      = 1'b0;
        bus.tx_ready_i         = 1'b0;
        model_reset();
        #12;
        chk("rst_gpio", bus.gpio_o, 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data_o), 32'h0);
        chk("rst_status", bus.data_mem_out_data_o, 32'h1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // RAM write, read-during-write returns the old word
        step(5, 32'h1111_1111, 1, 0);
        step(5, 32'hDEAD_BEEF, 1, 0);
        step(5, 0, 0, 0);
        chk("ram5", bus.data_mem_out_data_o, 32'hDEAD_BEEF);

        // GPIO
        step(MM + 1, 32'h0000_00A5, 1, 0);
        chk("gpio_a5", bus.gpio_o, 32'h0000_00A5);
        step(MM + 1, 0, 0, 0);

        // Cycle counter wrap
        step(MM, 32'hFFFF_FFFE, 1, 0);
        for (int i = 0; i < 4; i++) step(MM, 0, 0, 0);

        // Overfill with consumer stalled, then drain
        for (int i = 1; i <= 9; i++) step(MM + 2, 32'(i), 1, 0);
        step(MM + 3, 0, 0, 0);
        bus.data_mem_address_i = MM + 3;
        #1;
        chk("full_status", bus.data_mem_out_data_o, 32'h0000_0806);
        for (int i = 0; i < 10; i++) step(MM + 2, 0, 0, 1);

        // Push while full with a simultaneous pop
        for (int i = 0; i < 8; i++) step(MM + 2, 32'(8'hA0 + i), 1, 0);
        step(MM + 3, 32'h4, 1, 0);
        step(MM + 2, 32'h55, 1, 1);
        for (int i = 0; i < 9; i++) step(MM + 3, 0, 0, 1);
        chk("last_byte", 32'(bus.tx_data_o), 32'h55);

        // Unmapped write and bad_addr clear
        step(32'h0001_0000, 32'h1234, 1, 0);
        step(32'h0001_0000, 0, 0, 0);
        step(MM + 3, 32'h8, 1, 0);
        step(MM + 3, 0, 0, 0);

        // Reset in the middle of traffic
        step(MM + 2, 32'h77, 1, 0);
        step(MM + 1, 32'hCAFE, 1, 0);
        RST = 1'b1;
        #1;
        chk("midrst_gpio", bus.gpio_o, 32'h0);
        chk("midrst_valid", 32'(bus.tx_valid_o), 32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step(5, 0, 0, 0);

        for (int i = 0; i < 16; i++) step(32'(i), $urandom, 1, 0);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'($urandom_range(0, 15));
                1, 2: a = MM + 32'($urandom_range(0, 3));
                default: a = 32'h0001_0000 + 32'($urandom_range(0, 3));
            endcase
            d = $urandom;
            step(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
